alu_src_arbiter: RTL

Shares one ALU and its 2:1 operand-B mux (5-bit shamt input on `d0`, 32-bit register input on `d1`) between two requesters. Requester 0 issues shift-type operations that use a shift amount. Requester 1 issues register-register operations. The block arbitrates round-robin, latches the winner's operands, drives the mux select and inputs plus the ALU operands for one cycle, and captures the ALU result. It returns the result over a valid/ready response port tagged with the requester id. It sits between the issue logic and the shared ALU in the datapath.

---
 rtl/alu_src_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_src_arbiter.sv
// Round-robin sharing of one ALU and its operand-B mux between a shift requester (0)
// and a register requester (1). Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_src_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [4:0]  req0_shamt,
   input  logic [2:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_op,
   output logic        mux_s,
   output logic [4:0]  mux_d0,
   output logic [31:0] mux_d1,
   output logic [31:0] alu_a,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_y,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data
);

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;
   localparam int OP_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic acc_win;
   logic grant0, grant1;
   logic accept;

   logic               sel_p0;
   logic [SHAMT_W-1:0] d0_p0;
   logic [DATA_W-1:0]  d1_p0;
   logic [DATA_W-1:0]  a_p0;
   logic [OP_W-1:0]    op_p0;
   logic               id_p0;
   logic [DATA_W-1:0]  data_p1;
   logic               vld_p1;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
   end
`else
   // last_grant = 1 means requester 1 won most recently, so requester 0 wins a tie
   logic last_grant;

   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= req1_ready;
   end
`endif

   // Readies are held low while reset is asserted even though the state decodes as IDLE
   assign acc_win    = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
   assign req0_ready = acc_win & grant0;
   assign req1_ready = acc_win & grant1;
   assign accept     = req0_ready | req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = accept ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- stage p0: drive registers, loaded only on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_p0 <= 1'b0;
         d0_p0  <= '0;
         d1_p0  <= '0;
         a_p0   <= '0;
         op_p0  <= '0;
         id_p0  <= 1'b0;
      end else if (accept) begin
         sel_p0 <= req1_ready;
         d0_p0  <= req1_ready ? '0 : req0_shamt;
         d1_p0  <= req1_ready ? req1_b : '0;
         a_p0   <= req1_ready ? req1_a : req0_a;
         op_p0  <= req1_ready ? req1_op : req0_op;
         id_p0  <= req1_ready;
      end
   end

   // ---- stage p1: ALU result captured at the end of the ISSUE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_p1 <= '0;
      else if (state == ISSUE)
         data_p1 <= alu_y;
   end

   assign vld_p1    = (state == RESP);

   assign mux_s     = sel_p0;
   assign mux_d0    = d0_p0;
   assign mux_d1    = d1_p0;
   assign alu_a     = a_p0;
   assign alu_op    = op_p0;
   assign rsp_valid = vld_p1;
   assign rsp_id    = id_p0;
   assign rsp_data  = data_p1;

endmodule
